// File: rtl/adc_sampler.sv
// Periodic sampler for a 10-bit SPI ADC: one command/readback frame per sample tick.
// Define ADC_AVG_EN to average each conversion with the previous one.
module adc_sampler #(
  parameter int SCK_HALF      = 25,
  parameter int SAMPLE_PERIOD = 5000
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       channel,
  output logic       adc_cs_n,
  output logic       adc_sck,
  output logic       adc_sdi,
  input  logic       adc_sdo,
  output logic [9:0] sample,
  output logic       data_valid,
  output logic       busy,
  output logic       overrun
);

  localparam int TICK_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int HALF_W = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_PERIOD - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(SCK_HALF - 1);
  localparam logic [3:0]        LAST_BIT  = 4'd15;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [TICK_W-1:0]   tick_cnt;
  logic [HALF_W-1:0]   half_cnt;
  logic [HALF_W-1:0]   half_next;
  logic [3:0]          bit_cnt;
  logic [3:0]          bit_next;
  logic                sck_phase;
  logic                phase_next;
  logic                chan_lat;
  logic                chan_next;
  logic [9:0]          shift_reg;
  logic                tick;
  logic                half_last;
  logic                capture;
  logic                load_sample;
  logic                cs_n_next;
  logic                sck_next;
  logic                sdi_next;

  // Command word: start, single-ended, channel, MSB-first, then zeros.
  function automatic logic cmd_bit(input logic [3:0] idx, input logic ch);
    case (idx)
      4'd0, 4'd1, 4'd3: cmd_bit = 1'b1;
      4'd2:             cmd_bit = ch;
      default:          cmd_bit = 1'b0;
    endcase
  endfunction

  assign tick      = (tick_cnt == TICK_LAST);
  assign half_last = (half_cnt == HALF_LAST);
  assign busy      = (state != IDLE);

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next  = state;
    half_next   = half_cnt;
    bit_next    = bit_cnt;
    phase_next  = sck_phase;
    chan_next   = chan_lat;
    capture     = 1'b0;
    load_sample = 1'b0;
    case (state)
      IDLE: begin
        if (tick && enable) begin
          state_next = SETUP;
          half_next  = '0;
          chan_next  = channel;
        end
      end
      SETUP: begin
        if (half_last) begin
          state_next = SHIFT;
          half_next  = '0;
          bit_next   = '0;
          phase_next = 1'b0;
        end else begin
          half_next = half_cnt + 1'b1;
        end
      end
      SHIFT: begin
        // First high-phase cycle is the one on which adc_sck has just risen.
        capture = sck_phase && (half_cnt == '0);
        if (half_last) begin
          half_next = '0;
          if (sck_phase) begin
            phase_next = 1'b0;
            if (bit_cnt == LAST_BIT) begin
              state_next = HOLD;
            end else begin
              bit_next = bit_cnt + 1'b1;
            end
          end else begin
            phase_next = 1'b1;
          end
        end else begin
          half_next = half_cnt + 1'b1;
        end
      end
      HOLD: begin
        if (half_last) begin
          state_next  = DONE;
          half_next   = '0;
          load_sample = 1'b1;
        end else begin
          half_next = half_cnt + 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Pins are registered from next-state values so they line up with the state.
    cs_n_next = !((state_next == SETUP) || (state_next == SHIFT));
    sck_next  = (state_next == SHIFT) && phase_next;
    sdi_next  = (state_next == SHIFT) && cmd_bit(bit_next, chan_next);
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state      <= IDLE;
      half_cnt   <= '0;
      bit_cnt    <= '0;
      sck_phase  <= 1'b0;
      chan_lat   <= 1'b0;
      adc_cs_n   <= 1'b1;
      adc_sck    <= 1'b0;
      adc_sdi    <= 1'b0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_next;
      half_cnt   <= half_next;
      bit_cnt    <= bit_next;
      sck_phase  <= phase_next;
      chan_lat   <= chan_next;
      adc_cs_n   <= cs_n_next;
      adc_sck    <= sck_next;
      adc_sdi    <= sdi_next;
      data_valid <= load_sample;
      if (tick && (state != IDLE)) begin
        overrun <= 1'b1;
      end
    end
  end

  // All 16 bits are shifted in; the six leading ones fall off the top.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      shift_reg <= '0;
    end else if (capture) begin
      shift_reg <= {shift_reg[8:0], adc_sdo};
    end
  end

`ifdef ADC_AVG_EN
  logic [9:0]  prev_conv;
  logic [10:0] avg_sum;

  assign avg_sum = {1'b0, shift_reg} + {1'b0, prev_conv};

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      sample    <= '0;
      prev_conv <= '0;
    end else if (load_sample) begin
      sample    <= avg_sum[10:1];
      prev_conv <= shift_reg;
    end
  end
`else
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      sample <= '0;
    end else if (load_sample) begin
      sample <= shift_reg;
    end
  end
`endif

endmodule

// File: tb/tb_adc_sampler.sv
// Self-checking bench for adc_sampler: default-rate DUT with an ADC model plus a
// fast-tick DUT to exercise dropped ticks and overrun.
module tb_adc_sampler;

  localparam int SCK_HALF = 25;
  localparam int SP       = 5000;
  localparam int SP2      = 500;
  localparam int LAT      = 34 * SCK_HALF + 1;

  logic       sysclk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       channel;
  logic       adc_cs_n;
  logic       adc_sck;
  logic       adc_sdi;
  logic       adc_sdo = 1'b0;
  logic [9:0] sample;
  logic       data_valid;
  logic       busy;
  logic       overrun;

  logic       rst2_n;
  logic       enable2;
  logic       cs2_n;
  logic       sck2;
  logic       sdi2;
  logic [9:0] sample2;
  logic       dv2;
  logic       busy2;
  logic       ovr2;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          sck_viol = 0;
  int          frames = 0;
  int          dv_times[$];
  logic [9:0]  dv_samples[$];
  int          dv2_times[$];
  logic [9:0]  adc_next = '0;
  logic [15:0] adc_word = '0;
  int          adc_bit = 0;
  logic [15:0] sdi_bits = '0;
  int          sdi_count = 0;

  always #5 sysclk = ~sysclk;

  adc_sampler #(.SCK_HALF(SCK_HALF), .SAMPLE_PERIOD(SP)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .enable(enable), .channel(channel),
    .adc_cs_n(adc_cs_n), .adc_sck(adc_sck), .adc_sdi(adc_sdi), .adc_sdo(adc_sdo),
    .sample(sample), .data_valid(data_valid), .busy(busy), .overrun(overrun)
  );

  adc_sampler #(.SCK_HALF(SCK_HALF), .SAMPLE_PERIOD(SP2)) dut_fast (
    .sysclk(sysclk), .rst_n(rst2_n), .enable(enable2), .channel(1'b0),
    .adc_cs_n(cs2_n), .adc_sck(sck2), .adc_sdi(sdi2), .adc_sdo(1'b0),
    .sample(sample2), .data_valid(dv2), .busy(busy2), .overrun(ovr2)
  );

  always @(posedge sysclk) cyc <= cyc + 1;

  always @(negedge sysclk) begin
    if (data_valid === 1'b1) begin
      dv_times.push_back(cyc);
      dv_samples.push_back(sample);
    end
    if (dv2 === 1'b1) dv2_times.push_back(cyc);
    if (rst_n && (adc_cs_n === 1'b1) && (adc_sck !== 1'b0)) sck_viol++;
    if (rst2_n && (cs2_n === 1'b1) && (sck2 !== 1'b0)) sck_viol++;
  end

  // ADC model: a frame presents {6 junk bits, conversion} MSB first, advancing on SCK fall.
  always @(negedge adc_cs_n) begin
    frames++;
    sdi_bits  = '0;
    sdi_count = 0;
    adc_word  = {6'($urandom), adc_next};
    adc_bit   = 15;
    adc_sdo   = adc_word[15];
  end

  always @(negedge adc_sck) begin
    if (adc_bit > 0) begin
      adc_bit--;
      adc_sdo = adc_word[adc_bit];
    end
  end

  always @(posedge adc_sck) begin
    sdi_bits = {sdi_bits[14:0], adc_sdi};
    sdi_count++;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge sysclk);
  endtask

  function automatic int expect_sample(input int conv, input int prev);
`ifdef ADC_AVG_EN
    return (conv + prev) / 2;
`else
    return conv + 0 * prev;
`endif
  endfunction

  function automatic logic [31:0] dv_time_at(input int idx);
    return (dv_times.size() > idx) ? 32'(dv_times[idx]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] dv_sample_at(input int idx);
    return (dv_samples.size() > idx) ? 32'(dv_samples[idx]) : 32'hFFFF_FFFF;
  endfunction

  initial begin
    #(60000 * 10);
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int r;
    int r2;
    int t;
    int prev;
    int conv;
    int next_free;
    int n;
    logic ch;
    logic ch_new;

    rst_n = 1'b0; rst2_n = 1'b0; enable = 1'b0; enable2 = 1'b1; channel = 1'b0;
    repeat (4) @(negedge sysclk);
    check_output("rst_cs_n", 32'(adc_cs_n), 32'd1);
    check_output("rst_sck", 32'(adc_sck), 32'd0);
    check_output("rst_sdi", 32'(adc_sdi), 32'd0);
    check_output("rst_sample", 32'(sample), 32'd0);
    check_output("rst_dv", 32'(data_valid), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_overrun", 32'(overrun), 32'd0);

    r = cyc; rst_n = 1'b1; rst2_n = 1'b1; enable = 1'b1;
    prev = 0; ch = 1'b0;
    $display("[TB] reset released at cycle %0d", r);

    wait_until(r + 2 * SP2 - 1);
    check_output("fast_ovr_before", 32'(ovr2), 32'd0);
    wait_until(r + 2 * SP2);
    check_output("fast_ovr_after", 32'(ovr2), 32'd1);

    for (int k = 0; k < 4; k++) begin
      t = r + SP - 1 + k * SP;
      conv = (k == 0) ? 'h2A5 : int'($urandom_range(0, 1023));
      adc_next = 10'(conv);
      ch_new = (k == 2) ? 1'b1 : 1'($urandom);
      wait_until(t);
      check_output("cs_high_at_tick", 32'(adc_cs_n), 32'd1);
      check_output("idle_at_tick", 32'(busy), 32'd0);
      wait_until(t + 1);
      check_output("cs_low_after_tick", 32'(adc_cs_n), 32'd0);
      wait_until(t + 300);
      check_output("busy_mid_frame", 32'(busy), 32'd1);
      if (k == 3) enable = 1'b0;
      else channel = ch_new;
      wait_until(t + LAT + 2);
      check_output("dv_count", 32'(dv_times.size()), 32'(k + 1));
      check_output("dv_time", dv_time_at(k), 32'(t + LAT));
      check_output("sample", dv_sample_at(k), 32'(expect_sample(conv, prev)));
      check_output("sdi_cmd", 32'(sdi_bits), 32'(16'hD000 | (int'(ch) << 13)));
      check_output("sck_rises", 32'(sdi_count), 32'd16);
      check_output("cs_high_after", 32'(adc_cs_n), 32'd1);
      prev = conv;
      if (k != 3) ch = ch_new;
    end

    t = r + SP - 1 + 4 * SP;
    wait_until(t + LAT + 10);
    check_output("no_frame_disabled", 32'(frames), 32'd4);
    check_output("no_dv_disabled", 32'(dv_times.size()), 32'd4);
    check_output("cs_idle_disabled", 32'(adc_cs_n), 32'd1);

    enable = 1'b1; channel = 1'($urandom); adc_next = 10'($urandom);
    t = r + SP - 1 + 5 * SP;
    wait_until(t + 400);
    check_output("cs_low_pre_abort", 32'(adc_cs_n), 32'd0);
    rst_n = 1'b0;
    wait_until(t + 401);
    check_output("abort_cs_n", 32'(adc_cs_n), 32'd1);
    check_output("abort_dv", 32'(data_valid), 32'd0);
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_sample", 32'(sample), 32'd0);
    wait_until(t + 403);
    r2 = cyc; rst_n = 1'b1; prev = 0;

    for (int m = 0; m < 2; m++) begin
      conv = (m == 0) ? 'h100 : 'h300;
      adc_next = 10'(conv);
      t = r2 + SP - 1 + m * SP;
      wait_until(t + LAT + 2);
      check_output("post_rst_dv_count", 32'(dv_times.size()), 32'(5 + m));
      check_output("post_rst_dv_time", dv_time_at(4 + m), 32'(t + LAT));
      check_output("post_rst_sample", dv_sample_at(4 + m), 32'(expect_sample(conv, prev)));
      prev = conv;
    end

    check_output("overrun_idle", 32'(overrun), 32'd0);
    check_output("fast_ovr_sticky", 32'(ovr2), 32'd1);
    check_output("sck_low_cs_high", 32'(sck_viol), 32'd0);

    // Fast DUT: a tick starts a frame only if the previous frame has fully finished.
    next_free = 0; n = 0;
    for (int i = 0; n < 6; i++) begin
      t = r + SP2 - 1 + i * SP2;
      if (t >= next_free) begin
        check_output("fast_dv_time",
                     (dv2_times.size() > n) ? 32'(dv2_times[n]) : 32'hFFFF_FFFF,
                     32'(t + LAT));
        next_free = t + LAT + 1;
        n++;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_sampler.md
ADC_SAMPLER -- requirements
Module: adc_sampler

Interface
REQ-001 SHALL have parameter SCK_HALF, default 25: sysclk cycles per half SCK period (1 MHz SCK at 50 MHz).
REQ-002 SHALL have parameter SAMPLE_PERIOD, default 5000: sysclk cycles per sample tick (10 kHz).
REQ-003 sysclk  in  1  system clock; all logic on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous and active-low.
REQ-005 enable  in  1  permits sample frames to start.
REQ-006 channel  in  1  ADC channel select (0 = CH0, 1 = CH1).
REQ-007 adc_cs_n  out  1  ADC chip select, active-low.
REQ-008 adc_sck  out  1  ADC serial clock.
REQ-009 adc_sdi  out  1  serial command to the ADC DIN pin.
REQ-010 adc_sdo  in  1  serial data from the ADC DOUT pin.
REQ-011 sample  out  10  latest conversion, offset binary; feeds the echo processor's data_in.
REQ-012 data_valid  out  1  one-cycle strobe; sample was updated this cycle.
REQ-013 busy  out  1  high while a frame is in progress.
REQ-014 overrun  out  1  sticky; a tick fell while busy.

Function
REQ-015 A free-running tick counter SHALL count 0..SAMPLE_PERIOD-1 and wrap; a tick occurs on the wrap cycle, independent of enable.
REQ-016 FSM states SHALL be IDLE, SETUP, SHIFT, HOLD, DONE.
REQ-017 IDLE->SETUP on a tick with enable=1; channel SHALL be latched on that cycle.
REQ-018 SETUP: adc_cs_n=0, adc_sck=0 for SCK_HALF cycles, then ->SHIFT.
REQ-019 SHIFT: 16 SCK periods, each SCK_HALF cycles low then SCK_HALF high; adc_sdi changes only when SCK is low.
REQ-020 Command bits on SCK periods 0..3, MSB first: 1 (start), 1 (single-ended), latched channel, 1 (MSB-first); adc_sdi=0 on periods 4..15.
REQ-021 adc_sdo SHALL be sampled on the sysclk cycle where adc_sck rises; bits from periods 6..15 form sample[9:0], MSB first; periods 0..5 discarded.
REQ-022 After period 15: ->HOLD, adc_sck=0, adc_cs_n=1 for SCK_HALF cycles, then ->DONE.
REQ-023 DONE (1 cycle): update sample, assert data_valid, ->IDLE.
REQ-024 Latency: data_valid SHALL assert exactly 34*SCK_HALF+1 cycles after the tick cycle (851 at default).
REQ-025 busy=1 in every state except IDLE.
REQ-026 A tick while busy SHALL be dropped (no queuing) and set overrun; overrun clears only on reset.
REQ-027 Deasserting enable mid-frame SHALL NOT abort it; no new frame starts while enable=0.
REQ-028 A channel change mid-frame SHALL take effect at the next frame.
REQ-029 sample SHALL hold its value between data_valid strobes.

Reset
REQ-030 While rst_n=0 at a sysclk edge: FSM->IDLE, tick counter=0, adc_cs_n=1, adc_sck=0, adc_sdi=0, sample=0, data_valid=0, busy=0, overrun=0.
REQ-031 Reset mid-frame SHALL abort the frame with no data_valid; the first tick after release occurs SAMPLE_PERIOD cycles after release.

Configuration
REQ-032 Macro ADC_AVG_EN: when defined, sample SHALL be (current + previous conversion) >> 1, using an 11-bit sum; previous=0 after reset; strobe timing unchanged.
REQ-033 Without ADC_AVG_EN, sample SHALL equal the raw conversion.

Verification
REQ-034 ADC model returns 10'h2A5, enable=1, channel=0 -> data_valid at tick+851; sample=10'h2A5; adc_sdi shows 1,1,0,1 then zeros.
REQ-035 Free run, 3 ticks -> exactly 3 data_valid strobes 5000 cycles apart; adc_cs_n high between frames; adc_sck stays low while adc_cs_n is high.
REQ-036 SAMPLE_PERIOD=500, SCK_HALF=25 -> second tick dropped, overrun=1, every other tick yields a frame.
REQ-037 rst_n=0 at cycle 400 of a frame -> adc_cs_n=1 on the next edge, no data_valid, sample=0.
REQ-038 ADC_AVG_EN defined, conversions 10'h100 then 10'h300 -> samples 10'h080 then 10'h200.
REQ-039 channel=1 with enable dropped mid-frame -> frame completes with third command bit 1, and no further frames start.
